// File: rtl/video_timing_if.sv
// ============================================================================
// Module   : video_timing_if
// Brief    : Pixel-source fetch and DVI-side output bundle for video_timing
// Revision : 1.0
// ============================================================================
`default_nettype none

interface video_timing_if #(
    parameter int CW = 12
);
    logic          ce;
    logic [7:0]    r;
    logic [7:0]    g;
    logic [7:0]    b;
    logic [CW-1:0] px;
    logic [CW-1:0] py;
    logic          fetch_de;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic [7:0]    vga_r;
    logic [7:0]    vga_g;
    logic [7:0]    vga_b;
    logic          line_start;
    logic          frame_start;
`ifdef VIDEO_TIMING_TESTPAT_EN
    logic          testpat;
`endif

    modport master (
`ifdef VIDEO_TIMING_TESTPAT_EN
        input  testpat,
`endif
        input  ce, r, g, b,
        output px, py, fetch_de, hsync, vsync, de,
        output vga_r, vga_g, vga_b, line_start, frame_start
    );

    modport slave (
`ifdef VIDEO_TIMING_TESTPAT_EN
        output testpat,
`endif
        output ce, r, g, b,
        input  px, py, fetch_de, hsync, vsync, de,
        input  vga_r, vga_g, vga_b, line_start, frame_start
    );
endinterface

`default_nettype wire

// File: rtl/video_timing.sv
// ============================================================================
// Module   : video_timing
// Brief    : Parametrised raster timing generator with latency-matched RGB.
//            Optional colour-bar source: VIDEO_TIMING_TESTPAT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module video_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0,
    parameter int LAT      = 1,
    parameter int CW       = 12
) (
    input  logic           clk,
    input  logic           rst,
    video_timing_if.master vif
);
    localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [CW-1:0] c_h_last     = CW'(c_h_total - 1);
    localparam logic [CW-1:0] c_v_last     = CW'(c_v_total - 1);
    localparam logic [CW-1:0] c_h_act      = CW'(H_ACTIVE);
    localparam logic [CW-1:0] c_v_act      = CW'(V_ACTIVE);
    localparam logic [CW-1:0] c_hs_start   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] c_hs_end     = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] c_vs_start   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] c_vs_end     = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          c_hpol       = (H_POL != 0);
    localparam logic          c_vpol       = (V_POL != 0);

    logic [CW-1:0] r_hc;
    logic [CW-1:0] r_vc;
    logic          w_fetch_de;
    logic [4:0]    w_ctl;
    logic [4:0]    w_ctl_d;
    logic [7:0]    w_pix_r;
    logic [7:0]    w_pix_g;
    logic [7:0]    w_pix_b;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_de;
    logic [7:0]    r_vga_r;
    logic [7:0]    r_vga_g;
    logic [7:0]    r_vga_b;
    logic          r_line_start;
    logic          r_frame_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hc <= '0;
            r_vc <= '0;
        end else if (vif.ce) begin
            if (r_hc == c_h_last) begin
                r_hc <= '0;
                r_vc <= (r_vc == c_v_last) ? '0 : r_vc + 1'b1;
            end else begin
                r_hc <= r_hc + 1'b1;
            end
        end
    end

    assign w_fetch_de = (r_hc < c_h_act) && (r_vc < c_v_act);

    // Sync bits travel as "inside window"; polarity is applied only at the output.
    assign w_ctl = {(r_hc >= c_hs_start) && (r_hc < c_hs_end),
                    (r_vc >= c_vs_start) && (r_vc < c_vs_end),
                    w_fetch_de,
                    r_hc == '0,
                    (r_hc == '0) && (r_vc == '0)};

    generate
        if (LAT == 0) begin : g_no_delay
            assign w_ctl_d = w_ctl;
        end else begin : g_delay
            logic [4:0] r_dly [LAT];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < LAT; i++) begin
                        r_dly[i] <= '0;
                    end
                end else if (vif.ce) begin
                    r_dly[0] <= w_ctl;
                    for (int i = 1; i < LAT; i++) begin
                        r_dly[i] <= r_dly[i-1];
                    end
                end
            end

            assign w_ctl_d = r_dly[LAT-1];
        end
    endgenerate

`ifdef VIDEO_TIMING_TESTPAT_EN
    localparam logic [CW-1:0] c_bw_last = CW'(H_ACTIVE / 8 - 1);

    logic [CW-1:0] r_bar_px;
    logic [2:0]    r_bar_idx;
    logic [CW-1:0] w_bar_px;
    logic [2:0]    w_bar_idx;

    // Line start restarts bar 0 on the same cycle it is first displayed.
    assign w_bar_px  = w_ctl_d[1] ? '0 : r_bar_px;
    assign w_bar_idx = w_ctl_d[1] ? '0 : r_bar_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bar_px  <= '0;
            r_bar_idx <= '0;
        end else if (vif.ce && w_ctl_d[2]) begin
            if ((w_bar_px == c_bw_last) && (w_bar_idx != 3'd7)) begin
                r_bar_px  <= '0;
                r_bar_idx <= w_bar_idx + 3'd1;
            end else begin
                r_bar_px  <= w_bar_px + 1'b1;
                r_bar_idx <= w_bar_idx;
            end
        end
    end

    assign w_pix_r = vif.testpat ? {8{~w_bar_idx[1]}} : vif.r;
    assign w_pix_g = vif.testpat ? {8{~w_bar_idx[2]}} : vif.g;
    assign w_pix_b = vif.testpat ? {8{~w_bar_idx[0]}} : vif.b;
`else
    assign w_pix_r = vif.r;
    assign w_pix_g = vif.g;
    assign w_pix_b = vif.b;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hsync       <= ~c_hpol;
            r_vsync       <= ~c_vpol;
            r_de          <= 1'b0;
            r_vga_r       <= '0;
            r_vga_g       <= '0;
            r_vga_b       <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (vif.ce) begin
            r_hsync       <= w_ctl_d[4] ? c_hpol : ~c_hpol;
            r_vsync       <= w_ctl_d[3] ? c_vpol : ~c_vpol;
            r_de          <= w_ctl_d[2];
            r_vga_r       <= w_ctl_d[2] ? w_pix_r : 8'h00;
            r_vga_g       <= w_ctl_d[2] ? w_pix_g : 8'h00;
            r_vga_b       <= w_ctl_d[2] ? w_pix_b : 8'h00;
            r_line_start  <= w_ctl_d[1];
            r_frame_start <= w_ctl_d[0];
        end
    end

    assign vif.px          = r_hc;
    assign vif.py          = r_vc;
    assign vif.fetch_de    = w_fetch_de;
    assign vif.hsync       = r_hsync;
    assign vif.vsync       = r_vsync;
    assign vif.de          = r_de;
    assign vif.vga_r       = r_vga_r;
    assign vif.vga_g       = r_vga_g;
    assign vif.vga_b       = r_vga_b;
    assign vif.line_start  = r_line_start;
    assign vif.frame_start = r_frame_start;

endmodule

`default_nettype wire
